// File: rtl/pad_unit_stream_pkg.sv
// Shared definitions for the padded tile streamer: pad modes, FSM states and
// the field widths used for pad amounts, row counters and signed coordinates.
package pad_unit_stream_pkg;

    typedef enum logic [1:0] {
        PAD_CONST     = 2'd0,
        PAD_REPLICATE = 2'd1,
        PAD_REFLECT   = 2'd2
    } pad_mode_e;

    typedef enum logic {
        PAD_IDLE = 1'b0,
        PAD_EMIT = 1'b1
    } pad_state_e;

    localparam int PAD_W   = 4;
    localparam int CNT_W   = 5;
    localparam int COORD_W = 8;

    // The reserved encoding falls back to constant padding.
    function automatic pad_mode_e decode_mode(input logic [1:0] mode);
        pad_mode_e m;
        case (mode)
            2'd1:    m = PAD_REPLICATE;
            2'd2:    m = PAD_REFLECT;
            default: m = PAD_CONST;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pad_index_map.sv
// Maps one output coordinate along a dimension to the input index it samples,
// applying replicate/reflect folding, plus a flag saying whether it was inside the tile.
module pad_index_map
    import pad_unit_stream_pkg::*;
#(
    parameter int DIM   = 8,
    parameter int IDX_W = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic [CNT_W-1:0] coord_i,
    input  logic [PAD_W-1:0] pad_i,
    input  pad_mode_e        mode_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             in_range_o
);

    localparam logic signed [COORD_W-1:0] ZERO_S   = '0;
    localparam logic signed [COORD_W-1:0] LAST_S   = COORD_W'(DIM - 1);
    localparam logic signed [COORD_W-1:0] MIRROR_S = COORD_W'(2 * (DIM - 1));

    logic signed [COORD_W-1:0] pos;
    logic signed [COORD_W-1:0] sel;

    always_comb begin
        pos        = $signed(COORD_W'(coord_i)) - $signed(COORD_W'(pad_i));
        in_range_o = (pos >= ZERO_S) && (pos <= LAST_S);
        sel        = pos;
        if (mode_i == PAD_REFLECT) begin
            if (pos < ZERO_S) begin
                sel = ZERO_S - pos;
            end else if (pos > LAST_S) begin
                sel = MIRROR_S - pos;
            end
        end
        // Replicate is exactly this clamp; for other modes it keeps lanes past
        // the row end from producing an illegal index.
        if (sel < ZERO_S) begin
            sel = ZERO_S;
        end else if (sel > LAST_S) begin
            sel = LAST_S;
        end
        idx_o = IDX_W'(sel);
    end

endmodule

// File: rtl/pad_unit_stream.sv
// Accepts one tile, pads it on all four sides (const/replicate/reflect) and
// streams the padded tile out one registered row per valid/ready beat.
module pad_unit_stream
    import pad_unit_stream_pkg::*;
#(
    parameter int DW      = 16,
    parameter int IN_H    = 8,
    parameter int IN_W    = 8,
    parameter int MAX_PAD = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [IN_H*IN_W*DW-1:0]           data_in,
    input  logic                              valid_in,
    output logic                              ready_in,
    input  logic [PAD_W-1:0]                  pad_top,
    input  logic [PAD_W-1:0]                  pad_bottom,
    input  logic [PAD_W-1:0]                  pad_left,
    input  logic [PAD_W-1:0]                  pad_right,
    input  logic [1:0]                        pad_mode,
    input  logic [DW-1:0]                     pad_value,
    output logic [(IN_W+2*MAX_PAD)*DW-1:0]    data_out,
    output logic [CNT_W-1:0]                  row_len,
    output logic [CNT_W-1:0]                  row_idx,
    output logic                              valid_out,
    output logic                              last_out,
    input  logic                              ready_out,
    output logic                              cfg_err
);

    localparam int OUT_LANES = IN_W + 2 * MAX_PAD;
    localparam int TILE_W    = IN_H * IN_W * DW;
    localparam int ROW_W     = OUT_LANES * DW;
    localparam int ROW_IW    = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int COL_IW    = (IN_W > 1) ? $clog2(IN_W) : 1;

    function automatic logic [PAD_W-1:0] clamp_pad(input logic [PAD_W-1:0] p);
        return (p > PAD_W'(MAX_PAD)) ? PAD_W'(MAX_PAD) : p;
    endfunction

    pad_state_e          state_q, state_d;
    logic [TILE_W-1:0]   tile_q, tile_d;
    pad_mode_e           mode_q, mode_d;
    logic [DW-1:0]       pad_value_q, pad_value_d;
    logic [PAD_W-1:0]    pt_q, pt_d;
    logic [PAD_W-1:0]    pl_q, pl_d;
    logic [PAD_W-1:0]    pr_q, pr_d;
    logic [CNT_W-1:0]    out_rows_q, out_rows_d;
    logic [CNT_W-1:0]    row_idx_q, row_idx_d;
    logic [CNT_W-1:0]    row_len_q, row_len_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                cfg_err_q, cfg_err_d;
    logic [ROW_W-1:0]    data_out_q, data_out_d;

    logic                is_idle;
    logic [TILE_W-1:0]   src_tile;
    pad_mode_e           src_mode;
    logic [DW-1:0]       src_pad_value;
    logic [PAD_W-1:0]    src_pt;
    logic [PAD_W-1:0]    src_pl;
    logic [PAD_W-1:0]    src_pr;
    logic [CNT_W-1:0]    src_row;
    logic [CNT_W-1:0]    src_len;
    logic [CNT_W-1:0]    row_next_idx;
    logic [ROW_IW-1:0]   row_sel;
    logic                row_in;
    logic [ROW_W-1:0]    row_next;
    logic [DW-1:0]       src_arr [IN_H][IN_W];

    // The row builder sees the live inputs while idle so the first row can be
    // registered on the accept edge; afterwards it sees the latched tile.
    always_comb begin
        is_idle      = (state_q == PAD_IDLE);
        row_next_idx = row_idx_q + CNT_W'(1);
        if (is_idle) begin
            src_tile      = data_in;
            src_mode      = decode_mode(pad_mode);
            src_pad_value = pad_value;
            src_pt        = clamp_pad(pad_top);
            src_pl        = clamp_pad(pad_left);
            src_pr        = clamp_pad(pad_right);
            src_row       = '0;
        end else begin
            src_tile      = tile_q;
            src_mode      = mode_q;
            src_pad_value = pad_value_q;
            src_pt        = pt_q;
            src_pl        = pl_q;
            src_pr        = pr_q;
            src_row       = row_next_idx;
        end
        src_len = CNT_W'(IN_W) + CNT_W'(src_pl) + CNT_W'(src_pr);
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < IN_H; gi++) begin : g_unpack_r
            for (gj = 0; gj < IN_W; gj++) begin : g_unpack_c
                assign src_arr[gi][gj] = src_tile[(gi*IN_W+gj)*DW +: DW];
            end
        end
    endgenerate

    pad_index_map #(.DIM(IN_H), .IDX_W(ROW_IW)) u_row_map (
        .coord_i    (src_row),
        .pad_i      (src_pt),
        .mode_i     (src_mode),
        .idx_o      (row_sel),
        .in_range_o (row_in)
    );

    generate
        for (gi = 0; gi < OUT_LANES; gi++) begin : g_lane
            logic [COL_IW-1:0] col_sel;
            logic              col_in;
            logic [DW-1:0]     lane;

            pad_index_map #(.DIM(IN_W), .IDX_W(COL_IW)) u_col_map (
                .coord_i    (CNT_W'(gi)),
                .pad_i      (src_pl),
                .mode_i     (src_mode),
                .idx_o      (col_sel),
                .in_range_o (col_in)
            );

            always_comb begin
                lane = src_arr[row_sel][col_sel];
                if (CNT_W'(gi) >= src_len) begin
                    lane = '0;
                end else if (!(row_in && col_in) && (src_mode == PAD_CONST)) begin
                    lane = src_pad_value;
                end
            end

            assign row_next[gi*DW +: DW] = lane;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        tile_d      = tile_q;
        mode_d      = mode_q;
        pad_value_d = pad_value_q;
        pt_d        = pt_q;
        pl_d        = pl_q;
        pr_d        = pr_q;
        out_rows_d  = out_rows_q;
        row_idx_d   = row_idx_q;
        row_len_d   = row_len_q;
        valid_d     = valid_q;
        last_d      = last_q;
        cfg_err_d   = 1'b0;
        data_out_d  = data_out_q;

        case (state_q)
            PAD_IDLE: begin
                if (valid_in) begin
                    tile_d      = data_in;
                    mode_d      = src_mode;
                    pad_value_d = pad_value;
                    pt_d        = src_pt;
                    pl_d        = src_pl;
                    pr_d        = src_pr;
                    out_rows_d  = CNT_W'(IN_H) + CNT_W'(src_pt) + CNT_W'(clamp_pad(pad_bottom));
                    row_idx_d   = '0;
                    row_len_d   = src_len;
                    data_out_d  = row_next;
                    valid_d     = 1'b1;
                    last_d      = (out_rows_d == CNT_W'(1));
                    cfg_err_d   = (pad_top > PAD_W'(MAX_PAD)) || (pad_bottom > PAD_W'(MAX_PAD)) ||
                                  (pad_left > PAD_W'(MAX_PAD)) || (pad_right > PAD_W'(MAX_PAD)) ||
                                  (pad_mode == 2'd3);
                    state_d     = PAD_EMIT;
                end
            end
            PAD_EMIT: begin
                if (valid_q && ready_out) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = PAD_IDLE;
                    end else begin
                        row_idx_d  = row_next_idx;
                        data_out_d = row_next;
                        last_d     = (row_next_idx == (out_rows_q - CNT_W'(1)));
                    end
                end
            end
            default: state_d = PAD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PAD_IDLE;
            tile_q      <= '0;
            mode_q      <= PAD_CONST;
            pad_value_q <= '0;
            pt_q        <= '0;
            pl_q        <= '0;
            pr_q        <= '0;
            out_rows_q  <= '0;
            row_idx_q   <= '0;
            row_len_q   <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            tile_q      <= tile_d;
            mode_q      <= mode_d;
            pad_value_q <= pad_value_d;
            pt_q        <= pt_d;
            pl_q        <= pl_d;
            pr_q        <= pr_d;
            out_rows_q  <= out_rows_d;
            row_idx_q   <= row_idx_d;
            row_len_q   <= row_len_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            cfg_err_q   <= cfg_err_d;
            data_out_q  <= data_out_d;
        end
    end

    assign ready_in  = is_idle;
    assign data_out  = data_out_q;
    assign row_len   = row_len_q;
    assign row_idx   = row_idx_q;
    assign valid_out = valid_q;
    assign last_out  = last_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pad_unit_stream.sv
// Scoreboard bench for pad_unit_stream: a padded-image reference model queues
// every expected row at tile accept, and a monitor checks each row handshake.
`timescale 1ns/1ps
module tb_pad_unit_stream;

    localparam int DW        = 16;
    localparam int IN_H      = 8;
    localparam int IN_W      = 8;
    localparam int MAX_PAD   = 4;
    localparam int OUT_LANES = IN_W + 2 * MAX_PAD;
    localparam int TW        = IN_H * IN_W * DW;
    localparam int OW        = OUT_LANES * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [TW-1:0] data_in;
    logic          valid_in;
    logic          ready_in;
    logic [3:0]    pad_top, pad_bottom, pad_left, pad_right;
    logic [1:0]    pad_mode;
    logic [DW-1:0] pad_value;
    logic [OW-1:0] data_out;
    logic [4:0]    row_len, row_idx;
    logic          valid_out, last_out, ready_out, cfg_err;

    typedef struct packed {
        logic [OW-1:0] data;
        logic [4:0]    len;
        logic [4:0]    idx;
        logic          last;
    } row_t;

    row_t          exp_q[$];
    row_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            stall_left = 0;
    int            stall_row = 0;
    bit            rand_ready = 1'b0;
    logic [TW-1:0] ramp;
    logic [TW-1:0] rnd_tile;
    logic [OW-1:0] snap;

    pad_unit_stream #(.DW(DW), .IN_H(IN_H), .IN_W(IN_W), .MAX_PAD(MAX_PAD)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .pad_top    (pad_top),
        .pad_bottom (pad_bottom),
        .pad_left   (pad_left),
        .pad_right  (pad_right),
        .pad_mode   (pad_mode),
        .pad_value  (pad_value),
        .data_out   (data_out),
        .row_len    (row_len),
        .row_idx    (row_idx),
        .valid_out  (valid_out),
        .last_out   (last_out),
        .ready_out  (ready_out),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: the padded image sampled at (r,k), straight from the padding rules.
    function automatic logic [DW-1:0] model_elem(input logic [TW-1:0] t, input int pt, input int pl,
                                                 input int mode, input logic [DW-1:0] pv,
                                                 input int r, input int k);
        int i;
        int j;
        i = r - pt;
        j = k - pl;
        if (!(i >= 0 && i < IN_H && j >= 0 && j < IN_W)) begin
            case (mode)
                1: begin
                    i = (i < 0) ? 0 : ((i > IN_H - 1) ? IN_H - 1 : i);
                    j = (j < 0) ? 0 : ((j > IN_W - 1) ? IN_W - 1 : j);
                end
                2: begin
                    if (i < 0) i = -i;
                    else if (i >= IN_H) i = 2 * (IN_H - 1) - i;
                    if (j < 0) j = -j;
                    else if (j >= IN_W) j = 2 * (IN_W - 1) - j;
                end
                default: return pv;
            endcase
        end
        return t[(i * IN_W + j) * DW +: DW];
    endfunction

    task automatic push_expected(input logic [TW-1:0] t, input int pt, input int pb, input int pl,
                                 input int pr, input int mode_raw, input logic [DW-1:0] pv);
        int   mode;
        int   rows;
        int   len;
        row_t e;
        pt   = (pt > MAX_PAD) ? MAX_PAD : pt;
        pb   = (pb > MAX_PAD) ? MAX_PAD : pb;
        pl   = (pl > MAX_PAD) ? MAX_PAD : pl;
        pr   = (pr > MAX_PAD) ? MAX_PAD : pr;
        mode = (mode_raw == 3) ? 0 : mode_raw;
        rows = IN_H + pt + pb;
        len  = IN_W + pl + pr;
        for (int r = 0; r < rows; r++) begin
            e.data = '0;
            for (int k = 0; k < len; k++) begin
                e.data[k * DW +: DW] = model_elem(t, pt, pl, mode, pv, r, k);
            end
            e.len  = 5'(len);
            e.idx  = 5'(r);
            e.last = (r == rows - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_tile(input logic [TW-1:0] t, input int pt, input int pb, input int pl,
                             input int pr, input int mode, input logic [DW-1:0] pv);
        int waited;
        bit exp_err;
        waited     = 0;
        data_in    = t;
        pad_top    = 4'(pt);
        pad_bottom = 4'(pb);
        pad_left   = 4'(pl);
        pad_right  = 4'(pr);
        pad_mode   = 2'(mode);
        pad_value  = pv;
        valid_in   = 1'b1;
        while (!ready_in) begin
            @(posedge clk);
            #1;
            waited++;
            if (waited > 1000) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: ready_in stayed %0b for %0d cycles, required 1", ready_in, waited);
                valid_in = 1'b0;
                return;
            end
        end
        exp_err = (pt > MAX_PAD) || (pb > MAX_PAD) || (pl > MAX_PAD) || (pr > MAX_PAD) || (mode == 3);
        push_expected(t, pt, pb, pl, pr, mode, pv);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        chk("cfg_err_pulse", OW'(cfg_err), OW'(exp_err));
        chk("first_row_valid", OW'(valid_out), OW'(1));
        chk("first_row_idx", OW'(row_idx), OW'(0));
        chk("busy_ready_in", OW'(ready_in), OW'(0));
        $display("tile mode=%0d pads t%0d b%0d l%0d r%0d pv=%h waited=%0d queued=%0d",
                 mode, pt, pb, pl, pr, pv, waited, exp_q.size());
        @(posedge clk);
        #1;
        chk("cfg_err_clear", OW'(cfg_err), OW'(0));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 || valid_out) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 3000) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: %0d rows still expected, valid_out %0b", exp_q.size(), valid_out);
                exp_q.delete();
                break;
            end
        end
        chk("idle_ready_in", OW'(ready_in), OW'(1));
    endtask

    task automatic wait_row(input int r);
        int n;
        n = 0;
        while (!(valid_out && row_idx == 5'(r))) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL wait_row_timeout: row_idx %0d valid %0b, required row %0d", row_idx, valid_out, r);
                break;
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready_in"}, OW'(ready_in), OW'(1));
        chk({tag, "_valid_out"}, OW'(valid_out), OW'(0));
        chk({tag, "_last_out"}, OW'(last_out), OW'(0));
        chk({tag, "_row_idx"}, OW'(row_idx), OW'(0));
        chk({tag, "_row_len"}, OW'(row_len), OW'(0));
        chk({tag, "_cfg_err"}, OW'(cfg_err), OW'(0));
        chk({tag, "_data_out"}, data_out, OW'(0));
    endtask

    // Downstream ready: directed stall at a chosen row, otherwise random or always-on.
    initial begin
        ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && valid_out && row_idx == 5'(stall_row)) begin
                ready_out = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                ready_out = ($urandom_range(3) != 0);
            end else begin
                ready_out = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && valid_out && ready_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_row: row_idx %0d presented, required none", row_idx);
            end else begin
                mon_e = exp_q.pop_front();
                chk("row_data", data_out, mon_e.data);
                chk("row_len", OW'(row_len), OW'(mon_e.len));
                chk("row_idx", OW'(row_idx), OW'(mon_e.idx));
                chk("last_out", OW'(last_out), OW'(mon_e.last));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        data_in    = '0;
        valid_in   = 1'b0;
        pad_top    = '0;
        pad_bottom = '0;
        pad_left   = '0;
        pad_right  = '0;
        pad_mode   = '0;
        pad_value  = '0;
        for (int r = 0; r < IN_H; r++) begin
            for (int c = 0; c < IN_W; c++) begin
                ramp[(r * IN_W + c) * DW +: DW] = DW'(r * IN_W + c);
            end
        end

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases from the padding rules.
        send_tile(ramp, 1, 1, 1, 1, 0, 16'h0007);
        wait_drain();
        send_tile(ramp, 2, 0, 3, 0, 1, 16'h0000);
        wait_drain();
        send_tile(ramp, 2, 2, 2, 2, 2, 16'h0000);
        wait_drain();

        // Backpressure: five stalled cycles on row 3.
        rand_ready = 1'b0;
        stall_row  = 3;
        stall_left = 5;
        send_tile(ramp, 1, 1, 1, 1, 0, 16'h0007);
        wait_row(3);
        snap = data_out;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk("stall_data_hold", data_out, snap);
            chk("stall_row_idx", OW'(row_idx), OW'(3));
            chk("stall_valid", OW'(valid_out), OW'(1));
            chk("stall_ready_in", OW'(ready_in), OW'(0));
        end
        wait_drain();

        // Out-of-range pad and reserved mode.
        send_tile(ramp, 9, 1, 2, 0, 3, 16'hABCD);
        wait_drain();

        // Reset in the middle of a tile.
        rand_ready = 1'b1;
        send_tile(ramp, 2, 2, 2, 2, 2, 16'h0000);
        wait_row(4);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_idle_outputs("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_valid", OW'(valid_out), OW'(0));
        chk("post_reset_ready_in", OW'(ready_in), OW'(1));
        send_tile(ramp, 1, 3, 0, 4, 1, 16'h0055);
        wait_drain();

        // Random tiles with valid held while busy and random downstream ready.
        for (int n = 0; n < 25; n++) begin
            int pt, pb, pl, pr;
            for (int e = 0; e < IN_H * IN_W; e++) begin
                rnd_tile[e * DW +: DW] = DW'($urandom);
            end
            pt = ($urandom_range(5) == 0) ? int'($urandom_range(15)) : int'($urandom_range(MAX_PAD));
            pb = ($urandom_range(5) == 0) ? int'($urandom_range(15)) : int'($urandom_range(MAX_PAD));
            pl = ($urandom_range(5) == 0) ? int'($urandom_range(15)) : int'($urandom_range(MAX_PAD));
            pr = ($urandom_range(5) == 0) ? int'($urandom_range(15)) : int'($urandom_range(MAX_PAD));
            send_tile(rnd_tile, pt, pb, pl, pr, int'($urandom_range(3)), DW'($urandom));
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
